// File: rtl/fpu_float_share_arb.sv
// fpu_float_share_arb: shares one in-order pipelined FP unit among num_req_p requesters.
// Round-robin issue with a credit limit on in-flight ops; a tag FIFO of grantee ids
// routes each in-order result back to the requester that issued it.
// Optional build macro FPU_SHARE_ARB_PERF_EN adds per-requester issue/blocked counters.
// fp_float_decode_s is carried as a packed vector of decode_width_p bits.
module fpu_float_share_arb #(
   parameter int unsigned num_req_p        = 2,
   parameter int unsigned data_width_p     = 32,
   parameter int unsigned reg_addr_width_p = 5,
   parameter int unsigned max_inflight_p   = 4,
   parameter int unsigned decode_width_p   = 8
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic [num_req_p-1:0]                         v_i,
   input  logic [num_req_p-1:0][decode_width_p-1:0]     fp_float_decode_i,
   input  logic [num_req_p-1:0][data_width_p-1:0]       a_i,
   input  logic [num_req_p-1:0][data_width_p-1:0]       b_i,
   input  logic [num_req_p-1:0][reg_addr_width_p-1:0]   rd_i,
   output logic [num_req_p-1:0]                         ready_o,
   output logic                                         fpu_v_o,
   output logic [decode_width_p-1:0]                    fpu_decode_o,
   output logic [data_width_p-1:0]                      fpu_a_o,
   output logic [data_width_p-1:0]                      fpu_b_o,
   output logic [reg_addr_width_p-1:0]                  fpu_rd_o,
   input  logic                                         fpu_ready_i,
   input  logic                                         fpu_v_i,
   input  logic [data_width_p-1:0]                      fpu_result_i,
   input  logic [reg_addr_width_p-1:0]                  fpu_rd_i,
   output logic                                         fpu_yumi_o,
   output logic [num_req_p-1:0]                         v_o,
   output logic [data_width_p-1:0]                      result_o,
   output logic [reg_addr_width_p-1:0]                  rd_o,
   input  logic [num_req_p-1:0]                         yumi_i
`ifdef FPU_SHARE_ARB_PERF_EN
   ,
   output logic [num_req_p-1:0][31:0]                   issue_cnt_o,
   output logic [num_req_p-1:0][31:0]                   blocked_cnt_o
`endif
);

   localparam int unsigned IdW  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
   localparam int unsigned PtrW = (max_inflight_p > 1) ? $clog2(max_inflight_p) : 1;
   localparam int unsigned CntW = $clog2(max_inflight_p + 1);

   logic [IdW-1:0]  rr_q, rr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] occ_q, occ_d;
   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [IdW-1:0]  tag_q [max_inflight_p];

   logic           grant_v;
   logic [IdW-1:0] grant_id;
   logic           tag_full, tag_empty, credit_ok, issue_ok, issue;
   logic [IdW-1:0] head;
   logic           ret_v;

   assign tag_full  = (occ_q == CntW'(max_inflight_p));
   assign tag_empty = (occ_q == '0);
   assign credit_ok = (cnt_q < CntW'(max_inflight_p));
   // Reset gates every handshake so outputs drop the instant reset_i rises.
   assign issue_ok  = fpu_ready_i & credit_ok & ~tag_full & ~reset_i;
   assign issue     = grant_v & issue_ok;

   // Round-robin search: first valid requester starting at rr_q.
   always_comb begin
      int unsigned idx;
      grant_v  = 1'b0;
      grant_id = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         idx = 32'(rr_q) + k;
         if (idx >= num_req_p) idx = idx - num_req_p;
         if (!grant_v && v_i[idx]) begin
            grant_v  = 1'b1;
            grant_id = IdW'(idx);
         end
      end
   end

   // Issue side: one-hot ready to the grantee and operand mux toward the FPU.
   always_comb begin
      ready_o = '0;
      if (issue) ready_o[grant_id] = 1'b1;
      fpu_v_o      = issue;
      fpu_decode_o = fp_float_decode_i[grant_id];
      fpu_a_o      = a_i[grant_id];
      fpu_b_o      = b_i[grant_id];
      fpu_rd_o     = rd_i[grant_id];
   end

   assign head  = tag_q[rptr_q];
   // An empty tag FIFO means the result has no owner; it is never routed.
   assign ret_v = fpu_v_i & ~tag_empty & ~reset_i;

   // Return side: route the in-order result to the owner named by the head tag.
   always_comb begin
      v_o = '0;
      if (ret_v) v_o[head] = 1'b1;
      fpu_yumi_o = ret_v & yumi_i[head];
      result_o   = fpu_result_i;
      rd_o       = fpu_rd_i;
   end

   // Next-state: credit counter, FIFO occupancy/pointers and round-robin pointer.
   always_comb begin
      cnt_d  = cnt_q;
      occ_d  = occ_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      rr_d   = rr_q;
      unique case ({issue, fpu_yumi_o})
         2'b10: begin
            cnt_d = cnt_q + CntW'(1);
            occ_d = occ_q + CntW'(1);
         end
         2'b01: begin
            cnt_d = cnt_q - CntW'(1);
            occ_d = occ_q - CntW'(1);
         end
         default: ;
      endcase
      if (issue) begin
         wptr_d = (wptr_q == PtrW'(max_inflight_p - 1)) ? '0 : wptr_q + PtrW'(1);
         rr_d   = (grant_id == IdW'(num_req_p - 1)) ? '0 : grant_id + IdW'(1);
      end
      if (fpu_yumi_o) begin
         rptr_d = (rptr_q == PtrW'(max_inflight_p - 1)) ? '0 : rptr_q + PtrW'(1);
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rr_q   <= '0;
         cnt_q  <= '0;
         occ_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         rr_q   <= rr_d;
         cnt_q  <= cnt_d;
         occ_q  <= occ_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Tag storage; contents are qualified by occupancy, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (issue) tag_q[wptr_q] <= grant_id;
   end

`ifdef FPU_SHARE_ARB_PERF_EN
   logic [num_req_p-1:0][31:0] issue_cnt_q, blocked_cnt_q;

   // Per-requester issue and blocked-cycle counters; wrap naturally at 2^32.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         issue_cnt_q   <= '0;
         blocked_cnt_q <= '0;
      end else begin
         for (int unsigned i = 0; i < num_req_p; i++) begin
            if (ready_o[i]) issue_cnt_q[i] <= issue_cnt_q[i] + 32'd1;
            if (v_i[i] && !ready_o[i]) blocked_cnt_q[i] <= blocked_cnt_q[i] + 32'd1;
         end
      end
   end

   assign issue_cnt_o   = issue_cnt_q;
   assign blocked_cnt_o = blocked_cnt_q;
`endif

   // A result with no outstanding tag means the FPU and arbiter lost sync.
   a_no_orphan_result: assert property (@(posedge clk_i) disable iff (reset_i)
      !(fpu_v_i && tag_empty));

   a_occ_matches_credit: assert property (@(posedge clk_i) disable iff (reset_i)
      occ_q == cnt_q);

endmodule

// File: tb/tb_fpu_float_share_arb.sv
// tb_fpu_float_share_arb: directed and randomized bench for fpu_float_share_arb.
// A queue-based reference model tracks issue order, owners and credits; a
// latency-1 in-order FPU model feeds results back.
module tb_fpu_float_share_arb;

   localparam int N   = 2;
   localparam int W   = 32;
   localparam int RW  = 5;
   localparam int MAX = 4;
   localparam int DW  = 8;

   logic                     clk = 1'b0;
   logic                     reset_i;
   logic [N-1:0]             v_i;
   logic [N-1:0][DW-1:0]     dec_i;
   logic [N-1:0][W-1:0]      a_i, b_i;
   logic [N-1:0][RW-1:0]     rd_i;
   logic [N-1:0]             ready_o;
   logic                     fpu_v_o;
   logic [DW-1:0]            fpu_decode_o;
   logic [W-1:0]             fpu_a_o, fpu_b_o;
   logic [RW-1:0]            fpu_rd_o;
   logic                     fpu_ready_i;
   logic                     fpu_v_i;
   logic [W-1:0]             fpu_result_i;
   logic [RW-1:0]            fpu_rd_i;
   logic                     fpu_yumi_o;
   logic [N-1:0]             v_o;
   logic [W-1:0]             result_o;
   logic [RW-1:0]            rd_o;
   logic [N-1:0]             yumi_i;
`ifdef FPU_SHARE_ARB_PERF_EN
   logic [N-1:0][31:0]       issue_cnt_o, blocked_cnt_o;
`endif

   fpu_float_share_arb #(
      .num_req_p        (N),
      .data_width_p     (W),
      .reg_addr_width_p (RW),
      .max_inflight_p   (MAX),
      .decode_width_p   (DW)
   ) dut (
      .clk_i             (clk),
      .reset_i           (reset_i),
      .v_i               (v_i),
      .fp_float_decode_i (dec_i),
      .a_i               (a_i),
      .b_i               (b_i),
      .rd_i              (rd_i),
      .ready_o           (ready_o),
      .fpu_v_o           (fpu_v_o),
      .fpu_decode_o      (fpu_decode_o),
      .fpu_a_o           (fpu_a_o),
      .fpu_b_o           (fpu_b_o),
      .fpu_rd_o          (fpu_rd_o),
      .fpu_ready_i       (fpu_ready_i),
      .fpu_v_i           (fpu_v_i),
      .fpu_result_i      (fpu_result_i),
      .fpu_rd_i          (fpu_rd_i),
      .fpu_yumi_o        (fpu_yumi_o),
      .v_o               (v_o),
      .result_o          (result_o),
      .rd_o              (rd_o),
      .yumi_i            (yumi_i)
`ifdef FPU_SHARE_ARB_PERF_EN
      ,
      .issue_cnt_o       (issue_cnt_o),
      .blocked_cnt_o     (blocked_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state.
   int          m_own[$];    // owner of each in-flight op, oldest first
   logic [W-1:0]  fq_res[$];  // FPU model pipeline contents
   logic [RW-1:0] fq_rd[$];
   int          m_rr;
   int          m_issue[N];
   int          m_blocked[N];
   bit          fpu_gap;     // FPU model withholds its result this cycle
   int          obs_issue;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      m_own.delete();
      fq_res.delete();
      fq_rd.delete();
      m_rr = 0;
      for (int i = 0; i < N; i++) begin
         m_issue[i]   = 0;
         m_blocked[i] = 0;
      end
   endtask

   // One clock cycle: randomize operands, present FPU result, predict, compare, commit.
   task automatic step();
      int           g;
      bit           ok, efv, ey;
      logic [N-1:0] er, ev;
      for (int i = 0; i < N; i++) begin
         a_i[i]   = $urandom();
         b_i[i]   = $urandom();
         rd_i[i]  = RW'($urandom());
         dec_i[i] = DW'($urandom());
      end
      if (fq_res.size() > 0 && !fpu_gap) begin
         fpu_v_i      = 1'b1;
         fpu_result_i = fq_res[0];
         fpu_rd_i     = fq_rd[0];
      end else begin
         fpu_v_i      = 1'b0;
         fpu_result_i = $urandom();
         fpu_rd_i     = '0;
      end
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (g < 0 && v_i[i]) g = i;
      end
      ok  = fpu_ready_i && (m_own.size() < MAX);
      er  = '0;
      efv = 1'b0;
      if (g >= 0 && ok) begin
         er[g] = 1'b1;
         efv   = 1'b1;
      end
      ev = '0;
      ey = 1'b0;
      if (fpu_v_i && m_own.size() > 0) begin
         ev[m_own[0]] = 1'b1;
         ey           = yumi_i[m_own[0]];
      end
      check("ready_o", 64'(ready_o), 64'(er));
      check("fpu_v_o", 64'(fpu_v_o), 64'(efv));
      check("v_o", 64'(v_o), 64'(ev));
      check("fpu_yumi_o", 64'(fpu_yumi_o), 64'(ey));
      if (efv) begin
         check("fpu_a_o", 64'(fpu_a_o), 64'(a_i[g]));
         check("fpu_b_o", 64'(fpu_b_o), 64'(b_i[g]));
         check("fpu_rd_o", 64'(fpu_rd_o), 64'(rd_i[g]));
         check("fpu_decode_o", 64'(fpu_decode_o), 64'(dec_i[g]));
      end
      if (ev != '0) begin
         check("result_o", 64'(result_o), 64'(fq_res[0]));
         check("rd_o", 64'(rd_o), 64'(fq_rd[0]));
      end
      if (fpu_v_o === 1'b1) obs_issue++;
      @(posedge clk);
      if (ey) begin
         void'(m_own.pop_front());
         void'(fq_res.pop_front());
         void'(fq_rd.pop_front());
      end
      if (efv) begin
         m_own.push_back(g);
         fq_res.push_back(a_i[g] + b_i[g]);
         fq_rd.push_back(rd_i[g]);
         m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         if (er[i]) m_issue[i]++;
         if (v_i[i] && !er[i]) m_blocked[i]++;
      end
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready_o"}, 64'(ready_o), 64'(0));
      check({tag, "_fpu_v_o"}, 64'(fpu_v_o), 64'(0));
      check({tag, "_v_o"}, 64'(v_o), 64'(0));
      check({tag, "_fpu_yumi_o"}, 64'(fpu_yumi_o), 64'(0));
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      v_i         = '1;
      yumi_i      = '1;
      fpu_ready_i = 1'b1;
      fpu_v_i     = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
`ifdef FPU_SHARE_ARB_PERF_EN
      check("rst_issue_cnt", 64'(issue_cnt_o), 64'(0));
      check("rst_blocked_cnt", 64'(blocked_cnt_o), 64'(0));
`endif
      v_i     = '0;
      reset_i = 1'b0;
   endtask

   task automatic check_perf(input string tag);
`ifdef FPU_SHARE_ARB_PERF_EN
      for (int i = 0; i < N; i++) begin
         check({tag, "_issue_cnt"}, 64'(issue_cnt_o[i]), 64'(m_issue[i]));
         check({tag, "_blocked_cnt"}, 64'(blocked_cnt_o[i]), 64'(m_blocked[i]));
      end
`else
      vectors = vectors + 0;
`endif
   endtask

   initial begin
      reset_i      = 1'b1;
      v_i          = '0;
      dec_i        = '0;
      a_i          = '0;
      b_i          = '0;
      rd_i         = '0;
      fpu_ready_i  = 1'b0;
      fpu_v_i      = 1'b0;
      fpu_result_i = '0;
      fpu_rd_i     = '0;
      yumi_i       = '0;
      fpu_gap      = 1'b0;
      obs_issue    = 0;
      do_reset();

      // Reset mid-op: three ops in flight, then asynchronous reset.
      fpu_ready_i = 1'b1;
      v_i         = 2'b11;
      yumi_i      = 2'b00;
      fpu_gap     = 1'b1;
      repeat (3) step();
      #2;
      reset_i = 1'b1;
      fpu_v_i = 1'b1;
      yumi_i  = 2'b11;
      #1;
      check_reset_outputs("async_rst");
      clear_model();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      fpu_gap = 1'b0;
      v_i     = 2'b00;
      repeat (2) step();

      // Only requester 1 valid from rr_ptr=0, then both valid: requester 0 first.
      v_i    = 2'b10;
      yumi_i = 2'b11;
      obs_issue = 0;
      repeat (5) step();
      check("t4_issue_count", 64'(obs_issue), 64'(5));
      v_i = 2'b11;
      #1;
      check("t4_first_grant", 64'(ready_o), 64'(2'b01));

      // Both always valid with full consumption: alternating grants.
      repeat (8) step();

      // Credit limit: drain, then exactly MAX issues with no consumption.
      v_i    = 2'b00;
      yumi_i = 2'b11;
      repeat (6) step();
      v_i       = 2'b11;
      yumi_i    = 2'b00;
      obs_issue = 0;
      repeat (6) step();
      check("t3_issue_count", 64'(obs_issue), 64'(MAX));
      obs_issue = 0;
      yumi_i    = 2'b11;
      step();
      yumi_i = 2'b00;
      repeat (2) step();
      check("t3_reissue_count", 64'(obs_issue), 64'(1));

      // Drain to two in flight, then issue and retire together.
      v_i = 2'b00;
      for (int n = 0; n < 20 && m_own.size() > 2; n++) begin
         yumi_i = N'(1 << m_own[0]);
         step();
      end
      v_i    = 2'b01;
      yumi_i = 2'b11;
      step();
      // Wrong owner consuming must be ignored.
      v_i = 2'b00;
      if (m_own.size() > 0) yumi_i = N'(~(1 << m_own[0]));
      step();
      v_i       = 2'b11;
      yumi_i    = 2'b00;
      obs_issue = 0;
      repeat (4) step();
      check("t5_credit_left", 64'(obs_issue), 64'(MAX - 2));

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         v_i         = N'($urandom());
         fpu_ready_i = (($urandom() % 4) != 0);
         yumi_i      = N'($urandom());
         fpu_gap     = (($urandom() % 5) == 0);
         step();
      end
      check_perf("rand");

      // Counter scenario: 10 issues from 0, then 4 blocked cycles for 1.
      do_reset();
      fpu_gap     = 1'b0;
      fpu_ready_i = 1'b1;
      yumi_i      = 2'b11;
      v_i         = 2'b01;
      repeat (10) step();
      v_i         = 2'b10;
      fpu_ready_i = 1'b0;
      repeat (4) step();
`ifdef FPU_SHARE_ARB_PERF_EN
      check("t6_issue_cnt0", 64'(issue_cnt_o[0]), 64'(10));
      check("t6_blocked_cnt1", 64'(blocked_cnt_o[1]), 64'(4));
`endif
      check_perf("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
